// File: rtl/mpc_kob_pkg.sv
// Shared parameters, types and width helpers for the mpc_kob keep-order buffer.
// The same-cycle fill bypass is enabled by defining MPC_KOB_BYPASS_EN.
package mpc_kob_pkg;

   localparam int NCH_DEF   = 4;
   localparam int DEPTH_DEF = 8;
   localparam int NFILL_DEF = 2;
   localparam int DW_DEF    = 128;

   function automatic int kob_id_width(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int kob_ch_width(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   localparam int IDW_DEF = kob_id_width(DEPTH_DEF);
   localparam int CHW_DEF = kob_ch_width(NCH_DEF);

   // One bank response as seen on a fill port (default build widths).
   typedef struct packed {
      logic [CHW_DEF-1:0] ch;
      logic [IDW_DEF-1:0] id;
      logic [DW_DEF-1:0]  rdata;
   } kob_fill_t;

   typedef struct packed {
      logic [31:0] num_ch;
      logic [31:0] kob_size;
      logic [31:0] kob_width;
   } mpc_cfg_t;

   function automatic mpc_cfg_t mpc_build_config(input int num_ch, input int kob_size);
      mpc_cfg_t cfg;
      cfg.num_ch    = num_ch;
      cfg.kob_size  = kob_size;
      cfg.kob_width = kob_id_width(kob_size);
      return cfg;
   endfunction

endpackage

// File: rtl/mpc_kob_if.sv
// Channel-side and fill-side bus of the keep-order buffer; master drives requests,
// slave (the buffer) drives grants, in-order data and the error flag.
interface mpc_kob_if
   import mpc_kob_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int NFILL = NFILL_DEF,
   parameter int DW    = DW_DEF
);
   localparam int IDW = kob_id_width(DEPTH);
   localparam int CHW = kob_ch_width(NCH);

   logic [NCH-1:0]       alloc_valid_i;
   logic [NCH-1:0]       alloc_ready_o;
   logic [NCH*IDW-1:0]   alloc_id_o;
   logic [NFILL-1:0]     fill_valid_i;
   logic [NFILL*CHW-1:0] fill_ch_i;
   logic [NFILL*IDW-1:0] fill_id_i;
   logic [NFILL*DW-1:0]  fill_data_i;
   logic [NCH-1:0]       out_valid_o;
   logic [NCH-1:0]       out_ready_i;
   logic [NCH*DW-1:0]    out_data_o;
   logic                 err_o;

   modport master (
      output alloc_valid_i, fill_valid_i, fill_ch_i, fill_id_i, fill_data_i, out_ready_i,
      input  alloc_ready_o, alloc_id_o, out_valid_o, out_data_o, err_o
   );

   modport slave (
      input  alloc_valid_i, fill_valid_i, fill_ch_i, fill_id_i, fill_data_i, out_ready_i,
      output alloc_ready_o, alloc_id_o, out_valid_o, out_data_o, err_o
   );

endinterface

// File: rtl/mpc_kob_chan.sv
// One per-channel circular reorder queue: allocates rob ids, absorbs out-of-order
// fills and releases data in issue order. MPC_KOB_BYPASS_EN adds a fill-to-head bypass.
module mpc_kob_chan
   import mpc_kob_pkg::*;
#(
   parameter int  DEPTH = DEPTH_DEF,
   parameter int  NFILL = NFILL_DEF,
   parameter int  DW    = DW_DEF,
   localparam int IDW   = kob_id_width(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   output logic [IDW-1:0]       alloc_id,
   input  logic [NFILL-1:0]     fill_hit,
   input  logic [NFILL*IDW-1:0] fill_id,
   input  logic [NFILL*DW-1:0]  fill_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic                 err_pulse
);
   localparam logic [IDW:0] FULL = (IDW+1)'(DEPTH);

   logic [IDW-1:0]   head, tail;
   logic [IDW:0]     count;
   logic [DEPTH-1:0] filled;
   logic [DW-1:0]    mem [DEPTH];

   logic [IDW-1:0]   fid  [NFILL];
   logic [DW-1:0]    fdat [NFILL];
   logic [NFILL-1:0] dup, legal;
   logic             head_valid, byp_hit, push, pop, byp_take;
   logic [DW-1:0]    byp_data;

   for (genvar p = 0; p < NFILL; p++) begin : g_port
      assign fid[p]  = fill_id[p*IDW +: IDW];
      assign fdat[p] = fill_data[p*DW +: DW];
   end

   // A higher port colliding with a lower one on the same id loses and is flagged.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      dup       = '0;
      legal     = '0;
      err_pulse = 1'b0;
      for (int p = 0; p < NFILL; p++) begin
         for (int q = 0; q < p; q++)
            if (fill_hit[q] && fid[q] == fid[p]) dup[p] = 1'b1;
         legal[p] = fill_hit[p] && !dup[p] && !filled[fid[p]]
                    && ({1'b0, fid[p] - head} < count);
         if (fill_hit[p] && !legal[p]) err_pulse = 1'b1;
      end
   end

`ifdef MPC_KOB_BYPASS_EN
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int p = NFILL - 1; p >= 0; p--)
         if (legal[p] && fid[p] == head) begin
            byp_hit  = 1'b1;
            byp_data = fdat[p];
         end
   end
`else
   assign byp_hit  = 1'b0;
   assign byp_data = '0;
`endif

   assign alloc_ready = (count != FULL);
   assign alloc_id    = tail;
   assign head_valid  = (count != '0) && filled[head];
   assign out_valid   = head_valid || byp_hit;
   assign out_data    = head_valid ? mem[head] : byp_data;
   assign push        = alloc_valid && alloc_ready;
   assign pop         = out_valid && out_ready;
   assign byp_take    = pop && !head_valid;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head   <= '0;
         tail   <= '0;
         count  <= '0;
         filled <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         // A forwarded-and-consumed head fill never becomes resident.
         for (int p = 0; p < NFILL; p++)
            if (legal[p] && !(byp_take && fid[p] == head)) filled[fid[p]] <= 1'b1;
         if (pop) filled[head] <= 1'b0;
      end
   end

   // NOTE: data storage has no reset; validity is tracked entirely by the filled flags.
   always_ff @(posedge clk_i) begin
      for (int p = 0; p < NFILL; p++)
         if (legal[p]) mem[fid[p]] <= fdat[p];
   end

endmodule

// File: rtl/mpc_kob.sv
// Keep-order buffer top: decodes shared fill ports to channels, instantiates one
// queue per channel and keeps the sticky error flag. Option: MPC_KOB_BYPASS_EN.
module mpc_kob
   import mpc_kob_pkg::*;
#(
   parameter int NCH   = NCH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int NFILL = NFILL_DEF,
   parameter int DW    = DW_DEF
) (
   input  logic     clk_i,
   input  logic     rst_i,
   mpc_kob_if.slave bus
);
   localparam int IDW = kob_id_width(DEPTH);
   localparam int CHW = kob_ch_width(NCH);

   logic [NFILL-1:0] hit [NCH];
   logic [NCH-1:0]   err_pulse;
   logic             err_q;

   always_comb begin
      for (int c = 0; c < NCH; c++) begin
         hit[c] = '0;
         for (int p = 0; p < NFILL; p++)
            hit[c][p] = bus.fill_valid_i[p] && (bus.fill_ch_i[p*CHW +: CHW] == CHW'(c));
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_chan
      mpc_kob_chan #(
         .DEPTH (DEPTH),
         .NFILL (NFILL),
         .DW    (DW)
      ) u_chan (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .alloc_valid (bus.alloc_valid_i[c]),
         .alloc_ready (bus.alloc_ready_o[c]),
         .alloc_id    (bus.alloc_id_o[c*IDW +: IDW]),
         .fill_hit    (hit[c]),
         .fill_id     (bus.fill_id_i),
         .fill_data   (bus.fill_data_i),
         .out_valid   (bus.out_valid_o[c]),
         .out_ready   (bus.out_ready_i[c]),
         .out_data    (bus.out_data_o[c*DW +: DW]),
         .err_pulse   (err_pulse[c])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_q <= 1'b0;
      else       err_q <= err_q | (|err_pulse);
   end

   assign bus.err_o = err_q;

endmodule

// File: tb/tb_mpc_kob.sv
// Directed bench for mpc_kob: ordering, full/wrap, dual fills, errors, hold, reset
// and (when MPC_KOB_BYPASS_EN is defined) the zero-latency bypass.
module tb_mpc_kob;
   import mpc_kob_pkg::*;

   localparam int IDW = IDW_DEF;
   localparam int CHW = CHW_DEF;
   localparam int DW  = DW_DEF;
`ifdef MPC_KOB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mpc_kob_if bus ();

   mpc_kob dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int port, input kob_fill_t f);
      bus.fill_valid_i[port]           = 1'b1;
      bus.fill_ch_i[port*CHW +: CHW]   = f.ch;
      bus.fill_id_i[port*IDW +: IDW]   = f.id;
      bus.fill_data_i[port*DW +: DW]   = f.rdata;
   endtask

   task automatic fill_idle();
      bus.fill_valid_i = '0;
   endtask

   function automatic logic [IDW-1:0] aid(input int c);
      return bus.alloc_id_o[c*IDW +: IDW];
   endfunction

   function automatic logic [DW-1:0] odata(input int c);
      return bus.out_data_o[c*DW +: DW];
   endfunction

   logic [DW-1:0] d0, d1, d2, dx, da5, d5a, dh, p0, p1, dq;

   initial begin
      d0  = 128'hC0DE_0000_0000_0000_0000_0000_0000_0000;
      d1  = 128'hC0DE_1111_0000_0000_0000_0000_0000_0001;
      d2  = 128'hC0DE_2222_0000_0000_0000_0000_0000_0002;
      dx  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233;
      da5 = {16{8'hA5}};
      d5a = {16{8'h5A}};
      dh  = 128'h0BAD_F00D_1234_5678_9ABC_DEF0_4444_5555;
      p0  = 128'h0000_0000_0000_0000_0000_0000_0000_0F00;
      p1  = 128'h0000_0000_0000_0000_0000_0000_0000_0F11;
      dq  = 128'h7777_6666_5555_4444_3333_2222_1111_0000;

      bus.alloc_valid_i = '0;
      bus.fill_valid_i  = '0;
      bus.fill_ch_i     = '0;
      bus.fill_id_i     = '0;
      bus.fill_data_i   = '0;
      bus.out_ready_i   = '0;

      // Reset state
      repeat (3) tick();
      check("rst_alloc_ready", bus.alloc_ready_o, 4'hF);
      check("rst_alloc_id", bus.alloc_id_o, 12'h000);
      check("rst_out_valid", bus.out_valid_o, 4'h0);
      check("rst_err", bus.err_o, 1'b0);
      rst = 1'b0;
      tick();

      // Channel 0: three allocs, fills out of order, release in order
      for (int i = 0; i < 3; i++) begin
         bus.alloc_valid_i = 4'b0001;
         #1;
         check("t1_alloc_id", aid(0), i);
         tick();
      end
      bus.alloc_valid_i = '0;
      fill(0, '{ch: 2'd0, id: 3'd2, rdata: d2});
      #1;
      check("t1_fill2_valid", bus.out_valid_o[0], 1'b0);
      tick();
      fill(0, '{ch: 2'd0, id: 3'd0, rdata: d0});
      #1;
      check("t1_fill0_valid", bus.out_valid_o[0], BYP);
      tick();
      fill(0, '{ch: 2'd0, id: 3'd1, rdata: d1});
      #1;
      check("t1_head_valid", bus.out_valid_o[0], 1'b1);
      check("t1_head_data", odata(0), d0);
      tick();
      fill_idle();
      bus.out_ready_i = 4'b0001;
      #1;
      check("t1_out0", odata(0), d0);
      tick();
      check("t1_out1_valid", bus.out_valid_o[0], 1'b1);
      check("t1_out1", odata(0), d1);
      tick();
      check("t1_out2_valid", bus.out_valid_o[0], 1'b1);
      check("t1_out2", odata(0), d2);
      tick();
      check("t1_empty", bus.out_valid_o[0], 1'b0);
      bus.out_ready_i = '0;
      check("t1_err", bus.err_o, 1'b0);

      // Channel 1: fill to full, then pop with simultaneous alloc and wrap
      for (int i = 0; i < 8; i++) begin
         bus.alloc_valid_i = 4'b0010;
         #1;
         check("t2_alloc_id", aid(1), i);
         tick();
      end
      check("t2_full", bus.alloc_ready_o[1], 1'b0);
      bus.alloc_valid_i = '0;
      fill(0, '{ch: 2'd1, id: 3'd0, rdata: dx});
      tick();
      fill_idle();
      bus.alloc_valid_i = 4'b0010;
      bus.out_ready_i   = 4'b0010;
      #1;
      check("t2_refused", bus.alloc_ready_o[1], 1'b0);
      check("t2_pop_data", odata(1), dx);
      tick();
      bus.out_ready_i = '0;
      check("t2_ready_again", bus.alloc_ready_o[1], 1'b1);
      check("t2_wrap_id", aid(1), 3'd0);
      tick();
      bus.alloc_valid_i = '0;
      #1;
      check("t2_full_again", bus.alloc_ready_o[1], 1'b0);

      // Channels 2 and 3: both fill ports in one cycle
      bus.alloc_valid_i = 4'b1100;
      tick();
      bus.alloc_valid_i = '0;
      fill(0, '{ch: 2'd2, id: 3'd0, rdata: da5});
      fill(1, '{ch: 2'd3, id: 3'd0, rdata: d5a});
      #1;
      check("t3_same_cycle_valid", bus.out_valid_o[3:2], BYP ? 2'b11 : 2'b00);
      tick();
      fill_idle();
      #1;
      check("t3_valid", bus.out_valid_o[3:2], 2'b11);
      check("t3_data2", odata(2), da5);
      check("t3_data3", odata(3), d5a);
      check("t3_err", bus.err_o, 1'b0);
      bus.out_ready_i = 4'b1100;
      tick();
      bus.out_ready_i = '0;
      check("t3_drained", bus.out_valid_o[3:2], 2'b00);

      // Illegal fill to an unallocated id is dropped and flagged sticky
      fill(0, '{ch: 2'd0, id: 3'd5, rdata: dx});
      #1;
      check("t4_err_before", bus.err_o, 1'b0);
      tick();
      fill_idle();
      check("t4_err_set", bus.err_o, 1'b1);
      check("t4_dropped", bus.out_valid_o[0], 1'b0);
      repeat (2) tick();
      check("t4_err_sticky", bus.err_o, 1'b1);

      // Hold with out_ready low, then asynchronous reset mid-stream
      bus.alloc_valid_i = 4'b0001;
      #1;
      check("t5_alloc_id", aid(0), 3'd3);
      tick();
      bus.alloc_valid_i = '0;
      fill(0, '{ch: 2'd0, id: 3'd3, rdata: dh});
      tick();
      fill_idle();
      check("t5_valid", bus.out_valid_o[0], 1'b1);
      check("t5_data", odata(0), dh);
      repeat (3) tick();
      check("t5_hold_valid", bus.out_valid_o[0], 1'b1);
      check("t5_hold_data", odata(0), dh);
      rst = 1'b1;
      #1;
      check("t5_rst_ready", bus.alloc_ready_o, 4'hF);
      check("t5_rst_id", bus.alloc_id_o, 12'h000);
      check("t5_rst_valid", bus.out_valid_o, 4'h0);
      check("t5_rst_err", bus.err_o, 1'b0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Two ports on the same channel and id: lower port wins, error raised
      bus.alloc_valid_i = 4'b0100;
      #1;
      check("t6_alloc_id", aid(2), 3'd0);
      tick();
      bus.alloc_valid_i = '0;
      fill(0, '{ch: 2'd2, id: 3'd0, rdata: p0});
      fill(1, '{ch: 2'd2, id: 3'd0, rdata: p1});
      #1;
      check("t6_same_cycle_valid", bus.out_valid_o[2], BYP);
      tick();
      fill_idle();
      check("t6_valid", bus.out_valid_o[2], 1'b1);
      check("t6_lower_wins", odata(2), p0);
      check("t6_err", bus.err_o, 1'b1);
      bus.out_ready_i = 4'b0100;
      tick();
      bus.out_ready_i = '0;
      check("t6_drained", bus.out_valid_o[2], 1'b0);

`ifdef MPC_KOB_BYPASS_EN
      // Zero-latency bypass: fill to head consumed in the same cycle
      bus.alloc_valid_i = 4'b1000;
      tick();
      bus.alloc_valid_i = '0;
      fill(0, '{ch: 2'd3, id: 3'd0, rdata: dq});
      bus.out_ready_i = 4'b1000;
      #1;
      check("t7_byp_valid", bus.out_valid_o[3], 1'b1);
      check("t7_byp_data", odata(3), dq);
      tick();
      fill_idle();
      bus.out_ready_i = '0;
      #1;
      check("t7_consumed", bus.out_valid_o[3], 1'b0);
      check("t7_next_id", aid(3), 3'd1);
      check("t7_ready", bus.alloc_ready_o[3], 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
